max_pool_2x2: RTL

- Streaming 2x2 max-pooling stage with stride 2.
- Sits directly downstream of the convolution top and consumes its conv_res/valid_out pixel stream in row-major order.
- Keeps one half-width line buffer of horizontal pair maxima. Emits one pooled pixel per 2x2 block, so the output frame is half the input size in each dimension.

---
 rtl/max_pool_2x2.sv | 120 ++++++++++++
 1 files changed

// File: rtl/max_pool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a row-major pixel stream.
// Latency: pooled pixel registered 1 cycle after the accepting edge of the odd-column, odd-row sample.
// No backpressure: one sample per clock accepted, consumer must take every valid_out.
module max_pool_2x2 #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int BUFFER_LENGTH = 2000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PIXEL_WIDTH-1:0]           in_pixel,
    input  logic                             valid_in,
    input  logic [$clog2(BUFFER_LENGTH)-1:0] row_length,
    input  logic [15:0]                      row_count,
    output logic [PIXEL_WIDTH-1:0]           pool_out,
    output logic                             valid_out,
    output logic                             frame_done
);

    localparam int CW    = $clog2(BUFFER_LENGTH);
    localparam int DEPTH = BUFFER_LENGTH / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Half-width line buffer of horizontal pair maxima from the even row.
    logic [PIXEL_WIDTH-1:0] lbuf [DEPTH];

    logic [CW-1:0]          col_q;
    logic [15:0]            row_q;
    logic [PIXEL_WIDTH-1:0] pair_q;
    logic                   cfg_latched_q;
    logic [CW-1:0]          len_q;
    logic [15:0]            cnt_q;
    logic [PIXEL_WIDTH-1:0] pool_q;
    logic                   valid_q;
    logic                   done_q;

    logic [CW-1:0]          eff_len;
    logic [15:0]            eff_cnt;
    logic                   last_col;
    logic                   last_row;
    logic                   last_pair;
    logic                   last_prow;
    logic [AW-1:0]          lb_addr;
    logic [PIXEL_WIDTH-1:0] lb_rd;
    logic [PIXEL_WIDTH-1:0] pair_max;
    logic [PIXEL_WIDTH-1:0] pool_d;

    // Effective frame geometry, wrap detection, and the pooling datapath.
    always_comb begin
        // The first sample of a frame uses the live config; later samples use the latched copy.
        eff_len   = cfg_latched_q ? len_q : row_length;
        eff_cnt   = cfg_latched_q ? cnt_q : row_count;
        // Degenerate sizes keep the counter parked at 0 so no odd column/row is ever seen.
        last_col  = (eff_len < CW'(2)) || (col_q == eff_len - CW'(1));
        last_row  = (eff_cnt < 16'd2) || (row_q == eff_cnt - 16'd1);
        // Last complete pair in the row and last complete row pair in the frame;
        // an odd trailing column/row is excluded by rounding the size down to even.
        last_pair = ((col_q >> 1) == (eff_len >> 1) - CW'(1));
        last_prow = ((row_q >> 1) == (eff_cnt >> 1) - 16'd1);
        lb_addr   = AW'(col_q >> 1);
        lb_rd     = lbuf[lb_addr];
        pair_max  = (pair_q > in_pixel) ? pair_q : in_pixel;
        pool_d    = (lb_rd > pair_max) ? lb_rd : pair_max;
    end

    // Even-row pair maxima are stored for the odd row below; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && valid_in && col_q[0] && !row_q[0]) begin
            lbuf[lb_addr] <= pair_max;
        end
    end

    // Position counters, config latch, pair register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            pair_q        <= '0;
            cfg_latched_q <= 1'b0;
            len_q         <= '0;
            cnt_q         <= '0;
            pool_q        <= '0;
            valid_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (valid_in) begin
                if (!cfg_latched_q) begin
                    len_q         <= row_length;
                    cnt_q         <= row_count;
                    cfg_latched_q <= 1'b1;
                end
                if (last_col) begin
                    col_q <= '0;
                    if (last_row) begin
                        row_q         <= '0;
                        // End of frame: the next sample re-captures the config.
                        cfg_latched_q <= 1'b0;
                    end else begin
                        row_q <= row_q + 16'd1;
                    end
                end else begin
                    col_q <= col_q + CW'(1);
                end
                if (!col_q[0]) begin
                    pair_q <= in_pixel;
                end else if (row_q[0]) begin
                    pool_q  <= pool_d;
                    valid_q <= 1'b1;
                    done_q  <= last_pair && last_prow;
                end
            end
        end
    end

    assign pool_out   = pool_q;
    assign valid_out  = valid_q;
    assign frame_done = done_q;

endmodule
